verdict_trace_buffer: RTL and testbench

- Sits directly downstream of the monitor topEntity and consumes its per-cycle verdicts (output_0/output_1 plus their aktv flags).
- Each cycle in which at least one output is active becomes one timestamped record. Records are held in a FIFO and drained over a ready/valid stream toward the host/trace interface.
- Drops on overflow are counted, never silently lost, so that end-to-end tests can check verdict sequences and timing.

---
 rtl/verdict_trace_buffer.sv | 113 +++++++++++
 tb/tb_verdict_trace_buffer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/verdict_trace_buffer.sv
// Timestamped trace buffer for monitor verdicts: captures active outputs into a
// first-word-fall-through FIFO drained over ready/valid, counting overflow drops.
module verdict_trace_buffer #(
   parameter int DATA_W = 64,
   parameter int TS_W   = 32,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic signed [DATA_W-1:0]       output_0,
   input  logic                           output_0_aktv,
   input  logic signed [DATA_W-1:0]       output_1,
   input  logic                           output_1_aktv,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [TS_W-1:0]                m_ts,
   output logic [1:0]                     m_aktv,
   output logic signed [DATA_W-1:0]       m_data0,
   output logic signed [DATA_W-1:0]       m_data1,
   output logic [$clog2(DEPTH):0]         level,
   output logic                           overflow,
   output logic [CNT_W-1:0]               drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [TS_W-1:0]   ts;
      logic [1:0]        aktv;
      logic [DATA_W-1:0] d0;
      logic [DATA_W-1:0] d1;
   } rec_t;

   rec_t             mem_q [DEPTH];
   rec_t             wr_rec;
   rec_t             head;
   logic [TS_W-1:0]  ts_q, ts_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             capture, full, pop, wr, drop;

   assign capture = en & (output_0_aktv | output_1_aktv);
   assign full    = (level_q == LVL_W'(DEPTH));
   assign pop     = (level_q != '0) & m_ready;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign wr      = capture & (~full | pop);
   assign drop    = capture & full & ~pop;

   always_comb begin
      wr_rec.ts   = ts_q;
      wr_rec.aktv = {output_1_aktv, output_0_aktv};
      wr_rec.d0   = output_0_aktv ? output_0 : '0;
      wr_rec.d1   = output_1_aktv ? output_1 : '0;
   end

   // NOTE: every next-state signal gets a default first so no latch is inferred.
   always_comb begin
      ts_d     = en ? ts_q + 1'b1 : ts_q;
      wr_ptr_d = wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q | drop;
      drop_d   = drop_q;
      if (wr && !pop)
         level_d = level_q + 1'b1;
      else if (pop && !wr)
         level_d = level_q - 1'b1;
      if (drop && drop_q != '1)
         drop_d = drop_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         ts_q     <= ts_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   // NOTE: storage is not reset; stale entries are hidden because outputs are gated by level.
   always_ff @(posedge clk) begin
      if (wr)
         mem_q[wr_ptr_q] <= wr_rec;
   end

   assign head       = mem_q[rd_ptr_q];
   assign m_valid    = (level_q != '0);
   assign m_ts       = m_valid ? head.ts   : '0;
   assign m_aktv     = m_valid ? head.aktv : '0;
   assign m_data0    = m_valid ? head.d0   : '0;
   assign m_data1    = m_valid ? head.d1   : '0;
   assign level      = level_q;
   assign overflow   = ovf_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_verdict_trace_buffer.sv
// Directed self-checking bench for verdict_trace_buffer: capture, FWFT drain,
// overflow drop counting, enable gating and asynchronous reset.
module tb_verdict_trace_buffer;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic signed [63:0] output_0, output_1;
   logic               output_0_aktv, output_1_aktv;
   logic               m_valid, m_ready;
   logic [31:0]        m_ts;
   logic [1:0]         m_aktv;
   logic signed [63:0] m_data0, m_data1;
   logic [3:0]         level;
   logic               overflow;
   logic [15:0]        drop_count;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] ts_m    = '0;
   logic [31:0] base;

   verdict_trace_buffer dut (
      .clk(clk), .rst(rst), .en(en),
      .output_0(output_0), .output_0_aktv(output_0_aktv),
      .output_1(output_1), .output_1_aktv(output_1_aktv),
      .m_valid(m_valid), .m_ready(m_ready), .m_ts(m_ts), .m_aktv(m_aktv),
      .m_data0(m_data0), .m_data1(m_data1), .level(level),
      .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock edge; the reference timestamp advances whenever en is high at the edge.
   task automatic step();
      @(posedge clk);
      if (en) ts_m = ts_m + 1;
      #1;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; m_ready = 1'b0;
      output_0 = '0; output_1 = '0; output_0_aktv = 1'b0; output_1_aktv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_ts", 64'(m_ts), 64'd0);
      check("rst_data0", m_data0, 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_drop", 64'(drop_count), 64'd0);

      // Single capture at counter 10
      rst = 1'b1; en = 1'b1;
      repeat (10) step();
      output_0 = 64'sd5; output_0_aktv = 1'b1;
      step();
      output_0_aktv = 1'b0; output_0 = '0;
      check("t1_valid", 64'(m_valid), 64'd1);
      check("t1_ts", 64'(m_ts), 64'd10);
      check("t1_aktv", 64'(m_aktv), 64'd1);
      check("t1_data0", m_data0, 64'd5);
      check("t1_data1", m_data1, 64'd0);
      m_ready = 1'b1;
      step();
      check("t1_pop_valid", 64'(m_valid), 64'd0);
      check("t1_pop_level", 64'(level), 64'd0);
      step();
      check("t1_empty_ready", 64'(level), 64'd0);
      m_ready = 1'b0;

      // Both outputs active, held while not ready
      base = ts_m;
      output_0 = -64'sd3; output_1 = 64'sd7; output_0_aktv = 1'b1; output_1_aktv = 1'b1;
      step();
      output_0_aktv = 1'b0; output_1_aktv = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_ts", 64'(m_ts), 64'(base));
         check("t2_hold_aktv", 64'(m_aktv), 64'd3);
         check("t2_hold_d0", m_data0, 64'(-3));
         check("t2_hold_d1", m_data1, 64'd7);
         step();
      end
      m_ready = 1'b1;
      step();
      check("t2_drained", 64'(level), 64'd0);
      m_ready = 1'b0;

      // Overflow: 10 captures into 8 entries
      base = ts_m;
      output_0 = 64'sd1;
      for (int i = 0; i < 10; i++) begin
         output_1 = 64'(i); output_1_aktv = 1'b1;
         step();
      end
      output_1_aktv = 1'b0;
      check("t3_level", 64'(level), 64'd8);
      check("t3_ovf", 64'(overflow), 64'd1);
      check("t3_drop", 64'(drop_count), 64'd2);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("t3_ts", 64'(m_ts), 64'(base + 32'(i)));
         check("t3_d1", m_data1, 64'(i));
         check("t3_d0_masked", m_data0, 64'd0);
         step();
      end
      check("t3_empty", 64'(level), 64'd0);
      m_ready = 1'b0;

      // Full FIFO with simultaneous capture and pop
      for (int i = 0; i < 8; i++) begin
         output_1 = 64'(100 + i); output_1_aktv = 1'b1;
         step();
      end
      output_1 = 64'sd50; m_ready = 1'b1;
      step();
      output_1_aktv = 1'b0;
      check("t4_level", 64'(level), 64'd8);
      check("t4_drop", 64'(drop_count), 64'd2);
      for (int i = 0; i < 8; i++) begin
         check("t4_order", m_data1, (i < 7) ? 64'(101 + i) : 64'd50);
         step();
      end
      check("t4_empty", 64'(level), 64'd0);
      m_ready = 1'b0;

      // Enable low: no capture, timestamp frozen, drain still works
      for (int i = 0; i < 3; i++) begin
         output_0 = 64'(20 + i); output_0_aktv = 1'b1;
         step();
      end
      en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         output_0_aktv = (i % 2) == 0;
         output_1_aktv = (i % 2) != 0;
         step();
      end
      output_0_aktv = 1'b0; output_1_aktv = 1'b0;
      check("t5_level", 64'(level), 64'd3);
      base = ts_m;
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("t5_drain_d0", m_data0, 64'(20 + i));
         step();
      end
      check("t5_empty", 64'(level), 64'd0);
      m_ready = 1'b0; en = 1'b1;
      output_0 = 64'sd77; output_0_aktv = 1'b1;
      step();
      output_0_aktv = 1'b0;
      check("t5_frozen_ts", 64'(m_ts), 64'(base));
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;

      // Reset mid-drain with four records queued
      for (int i = 0; i < 4; i++) begin
         output_0 = 64'(i); output_0_aktv = 1'b1;
         step();
      end
      output_0_aktv = 1'b0;
      check("t6_level_pre", 64'(level), 64'd4);
      m_ready = 1'b1;
      rst = 1'b0;
      #1;
      check("t6_level", 64'(level), 64'd0);
      check("t6_valid", 64'(m_valid), 64'd0);
      check("t6_ovf", 64'(overflow), 64'd0);
      check("t6_drop", 64'(drop_count), 64'd0);
      m_ready = 1'b0; en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      ts_m = '0;
      en = 1'b1;
      repeat (3) step();
      output_0 = 64'sd9; output_0_aktv = 1'b1;
      step();
      output_0_aktv = 1'b0;
      check("t6_first_ts", 64'(m_ts), 64'd3);
      check("t6_first_d0", m_data0, 64'd9);
      check("t6_level_post", 64'(level), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
